// File: rtl/tcdm_varlat_pkg.sv
// Shared types for the variable-latency bank arbiter: master index type and outstanding-depth limits.
package tcdm_varlat_pkg;

    localparam int unsigned MaxOutstandingLimit = 8;
    localparam int unsigned MstIdxWidth         = 8;

    typedef logic [MstIdxWidth-1:0] mst_idx_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/varlat_id_fifo.sv
// In-order FIFO of granted master indices; head visible combinationally, push/pop take effect next edge.
// Backpressure: full_o/empty_o; a push while full or a pop while empty is ignored.
module varlat_id_fifo
    import tcdm_varlat_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  mst_idx_t push_dat_i,
    input  logic     pop_i,
    output mst_idx_t head_dat_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PtrW = ptr_width(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    mst_idx_t        mem_q [Depth];
    mst_idx_t        mem_d [Depth];
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (count_q == CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bank_arb_resp_demux_varlat.sv
// Round-robin arbiter of NumIn masters onto one bank, with in-order response routing; arbitration is combinational.
// Backpressure: gnt_i stalls the winner in place; req_o drops while MaxOutstanding requests are unanswered.
module bank_arb_resp_demux_varlat
    import tcdm_varlat_pkg::*;
#(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned LogNumIn       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]   data_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0] rdata_o,
    output logic                                 req_o,
    input  logic                                 gnt_i,
    output logic [ReqDataWidth-1:0]              data_o,
    input  logic                                 vld_i,
    input  logic [RespDataWidth-1:0]             rdata_i,
    output logic                                 spurious_vld_o
);

    localparam int unsigned Depth =
        (MaxOutstanding < 1) ? 1 :
        (MaxOutstanding > MaxOutstandingLimit) ? MaxOutstandingLimit : MaxOutstanding;

    logic [LogNumIn-1:0] ptr_q, ptr_d;
    logic [LogNumIn-1:0] winner;
    logic                win_found;
    logic                fifo_full, fifo_empty;
    logic                hs, pop;
    mst_idx_t            head_idx;

    // First pass finds a requester at/after the pointer, second pass wraps to index 0.
    always_comb begin
        winner    = ptr_q;
        win_found = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            if (!win_found && req_i[i] && (LogNumIn'(i) >= ptr_q)) begin
                win_found = 1'b1;
                winner    = LogNumIn'(i);
            end
        end
        for (int i = 0; i < NumIn; i++) begin
            if (!win_found && req_i[i]) begin
                win_found = 1'b1;
                winner    = LogNumIn'(i);
            end
        end
    end

    // Gated on registered full only, so a same-cycle response cannot reopen the request.
    assign req_o          = (|req_i) & ~fifo_full & ~rst_i;
    assign hs             = req_o & gnt_i;
    assign data_o         = data_i[winner];
    assign pop            = vld_i & ~fifo_empty & ~rst_i;
    assign spurious_vld_o = vld_i & fifo_empty & ~rst_i;
    assign rdata_o        = {NumIn{rdata_i}};

    always_comb begin
        gnt_o = '0;
        vld_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            gnt_o[i] = hs && (winner == LogNumIn'(i));
            vld_o[i] = pop && (head_idx == mst_idx_t'(i));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (winner == LogNumIn'(NumIn - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    varlat_id_fifo #(
        .Depth (Depth)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (hs),
        .push_dat_i (mst_idx_t'(winner)),
        .pop_i      (pop),
        .head_dat_o (head_idx),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_bank_arb_resp_demux_varlat.sv
// Directed-vector bench: each row drives one cycle of inputs and lists the hand-derived outputs for that cycle.
module tb_bank_arb_resp_demux_varlat;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [3:0]        req_i;
    logic [3:0][31:0]  data_i;
    logic [3:0]        gnt_o;
    logic [3:0]        vld_o;
    logic [3:0][31:0]  rdata_o;
    logic              req_o;
    logic              gnt_i;
    logic [31:0]       data_o;
    logic              vld_i;
    logic [31:0]       rdata_i;
    logic              spurious_vld_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    bank_arb_resp_demux_varlat #(
        .NumIn          (4),
        .ReqDataWidth   (32),
        .RespDataWidth  (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .data_i         (data_i),
        .gnt_o          (gnt_o),
        .vld_o          (vld_o),
        .rdata_o        (rdata_o),
        .req_o          (req_o),
        .gnt_i          (gnt_i),
        .data_o         (data_o),
        .vld_i          (vld_i),
        .rdata_i        (rdata_i),
        .spurious_vld_o (spurious_vld_o)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       gnt;
        logic       vld;
        logic       ereq;
        logic [3:0] egnt;
        logic [3:0] evld;
        logic       espur;
        int         esel;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [3:0] req, input logic gnt,
                                input logic vld, input logic ereq, input logic [3:0] egnt,
                                input logic [3:0] evld, input logic espur, input int esel);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.vld = vld;
        v.ereq = ereq; v.egnt = egnt; v.evld = evld; v.espur = espur; v.esel = esel;
        vecs.push_back(v);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0]       rd;
        logic [3:0][31:0]  exp_rdata;

        for (int k = 0; k < 4; k++) data_i[k] = 32'hA000_0000 + 32'(k);

        //   rst req     gnt   vld   ereq  egnt     evld     spur  sel
        // reset state (row 0 during reset with everything asserted)
        add(1, 4'hF,   1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        // all masters requesting, bank answers one cycle later: grants 0,1,2,3,0
        add(0, 4'hF,   1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 0);
        add(0, 4'hF,   1'b1, 1'b1, 1'b1, 4'b0010, 4'b0001, 1'b0, 1);
        add(0, 4'hF,   1'b1, 1'b1, 1'b1, 4'b0100, 4'b0010, 1'b0, 2);
        add(0, 4'hF,   1'b1, 1'b1, 1'b1, 4'b1000, 4'b0100, 1'b0, 3);
        add(0, 4'hF,   1'b1, 1'b1, 1'b1, 4'b0001, 4'b1000, 1'b0, 0);
        add(0, 4'h0,   1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 0);
        // response with nothing outstanding
        add(0, 4'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 0);
        add(0, 4'h0,   1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        // stall with gnt_i low: winner 1 held, pointer stays at 0
        add(1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1);
        add(0, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1);
        add(0, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1);
        add(0, 4'b1010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1);
        add(0, 4'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 0);
        // fill to MaxOutstanding=2, full blocks even with same-cycle pop
        add(0, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 0);
        add(0, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 0);
        add(0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 0);
        add(0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 0);
        // masters 2,0,3 with latencies 1,5,2
        add(0, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 2);
        add(0, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0100, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 3);
        add(0, 4'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 0);
        // reset with one request outstanding; later response is spurious
        add(0, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1);
        add(1, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 0);
        add(0, 4'h0,   1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
        add(0, 4'hF,   1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 0);
        add(0, 4'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            rd      = 32'hC0DE_0000 + 32'(r);
            rst_i   = vecs[r].rst;
            req_i   = vecs[r].req;
            gnt_i   = vecs[r].gnt;
            vld_i   = vecs[r].vld;
            rdata_i = rd;
            #2;
            exp_rdata = {4{rd}};
            check($sformatf("row%0d req_o", r), 128'(req_o), 128'(vecs[r].ereq));
            check($sformatf("row%0d gnt_o", r), 128'(gnt_o), 128'(vecs[r].egnt));
            check($sformatf("row%0d vld_o", r), 128'(vld_o), 128'(vecs[r].evld));
            check($sformatf("row%0d spurious_vld_o", r), 128'(spurious_vld_o), 128'(vecs[r].espur));
            if (vecs[r].evld != 4'b0000)
                check($sformatf("row%0d rdata_o", r), 128'(rdata_o), 128'(exp_rdata));
            if (vecs[r].ereq)
                check($sformatf("row%0d data_o", r), 128'(data_o), 128'(data_i[vecs[r].esel]));
            @(posedge clk_i);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
